// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: logical-immediate opcodes, canonical NOP, extender modes.
package mips_pkg;

    localparam logic [5:0]  OP_ANDI   = 6'h0C;
    localparam logic [5:0]  OP_ORI    = 6'h0D;
    localparam logic [5:0]  OP_XORI   = 6'h0E;
    localparam logic [5:0]  OP_LUI    = 6'h0F;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic        EXT_ZERO  = 1'b0;
    localparam logic        EXT_SIGN  = 1'b1;

endpackage

// File: rtl/mod_ext_type_decode.sv
// Immediate extension mode from opcode: logical immediates zero-extend, all others sign-extend.
module mod_ext_type_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       ext_type
);

    always_comb begin
        ext_type = EXT_SIGN;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext_type = EXT_ZERO;
            default:                          ext_type = EXT_SIGN;
        endcase
    end

endmodule

// File: rtl/mod_if_id_reg.sv
// IF/ID pipeline register with stall/flush and field split.
// Optional perf counters enabled by defining IF_ID_PERF_CNT_EN.
module mod_if_id_reg #(
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc_plus4,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc_plus4,
    output logic              id_valid,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [15:0]       id_imm,
    output logic              id_extender_type
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic if_ext_type;

    mod_ext_type_decode u_ext_dec (
        .opcode   (if_instr[31:26]),
        .ext_type (if_ext_type)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            id_instr         <= NOP_INSTR;
            id_pc_plus4      <= '0;
            id_valid         <= 1'b0;
            id_extender_type <= mips_pkg::EXT_ZERO;
        end else if (flush) begin
            id_instr         <= NOP_INSTR;
            id_pc_plus4      <= if_pc_plus4;
            id_valid         <= 1'b0;
            id_extender_type <= mips_pkg::EXT_ZERO;
        end else if (!stall) begin
            id_pc_plus4 <= if_pc_plus4;
            id_valid    <= if_valid;
            // invalid slots are loaded as canonical bubbles
            if (if_valid) begin
                id_instr         <= if_instr;
                id_extender_type <= if_ext_type;
            end else begin
                id_instr         <= NOP_INSTR;
                id_extender_type <= mips_pkg::EXT_ZERO;
            end
        end
    end

    assign id_opcode = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_shamt  = id_instr[10:6];
    assign id_funct  = id_instr[5:0];
    assign id_imm    = id_instr[15:0];

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (stall && !flush && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            // edges that write a bubble: flush, or an unstalled load of an invalid slot
            if ((flush || (!stall && !if_valid)) && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_if_id_reg.sv
// Self-checking bench for mod_if_id_reg: directed scenarios plus randomized traffic against a behavioural model.
module tb_mod_if_id_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, if_valid;
    logic [31:0] if_instr, if_pc_plus4;
    logic [31:0] id_instr, id_pc_plus4;
    logic        id_valid, id_extender_type;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    mod_if_id_reg #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_instr         (if_instr),
        .if_pc_plus4      (if_pc_plus4),
        .if_valid         (if_valid),
        .stall            (stall),
        .flush            (flush),
        .id_instr         (id_instr),
        .id_pc_plus4      (id_pc_plus4),
        .id_valid         (id_valid),
        .id_opcode        (id_opcode),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_shamt         (id_shamt),
        .id_funct         (id_funct),
        .id_imm           (id_imm),
        .id_extender_type (id_extender_type)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_bubble_cnt  (perf_bubble_cnt)
`endif
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference state
    logic [31:0] m_instr, m_pc;
    logic        m_valid, m_ext;
    longint unsigned m_stalls, m_flushes, m_bubbles;

    function automatic logic ext_of(input logic [31:0] instr);
        int unsigned op;
        op = int'(instr >> 26);
        return (op >= 12 && op <= 15) ? 1'b0 : 1'b1;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("instr",  {32'd0, id_instr},    {32'd0, m_instr});
        chk("pc",     {32'd0, id_pc_plus4}, {32'd0, m_pc});
        chk("valid",  {63'd0, id_valid},    {63'd0, m_valid});
        chk("ext",    {63'd0, id_extender_type}, {63'd0, m_ext});
        chk("fields", {32'd0, id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, {32'd0, m_instr});
        chk("imm",    {48'd0, id_imm},      {48'd0, m_instr[15:0]});
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_stall",  {32'd0, perf_stall_cnt},  m_stalls);
        chk("perf_flush",  {32'd0, perf_flush_cnt},  m_flushes);
        chk("perf_bubble", {32'd0, perf_bubble_cnt}, m_bubbles);
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc);
        rst = r; stall = s; flush = f; if_valid = v; if_instr = ins; if_pc_plus4 = pc;
        @(posedge clk);
        if (r) begin
            m_instr = '0; m_pc = '0; m_valid = 1'b0; m_ext = 1'b0;
            m_stalls = 0; m_flushes = 0; m_bubbles = 0;
        end else if (f) begin
            m_instr = '0; m_pc = pc; m_valid = 1'b0; m_ext = 1'b0;
            m_flushes = sat_inc(m_flushes);
            m_bubbles = sat_inc(m_bubbles);
        end else if (s) begin
            m_stalls = sat_inc(m_stalls);
        end else begin
            m_pc = pc; m_valid = v;
            m_instr = v ? ins : 32'h0;
            m_ext = v ? ext_of(ins) : 1'b0;
            if (!v) m_bubbles = sat_inc(m_bubbles);
        end
        #1;
        check_all();
    endtask

    localparam logic [31:0] ADDI = 32'h2008FFFF;
    localparam logic [31:0] ORI  = 32'h3508FFFF;

    initial begin
        logic [31:0] ins;
        m_instr = '0; m_pc = '0; m_valid = 1'b0; m_ext = 1'b0;
        m_stalls = 0; m_flushes = 0; m_bubbles = 0;

        // reset for two cycles
        step(1, 0, 0, 1, ADDI, 32'h100);
        step(1, 0, 0, 1, ADDI, 32'h100);
        chk("rst_instr", {32'd0, id_instr}, 64'h0);
        chk("rst_valid", {63'd0, id_valid}, 64'h0);
        chk("rst_ext",   {63'd0, id_extender_type}, 64'h0);

        // addi: sign-extended immediate
        step(0, 0, 0, 1, ADDI, 32'h104);
        chk("addi_imm", {48'd0, id_imm}, 64'hFFFF);
        chk("addi_ext", {63'd0, id_extender_type}, 64'h1);
        chk("addi_rt",  {59'd0, id_rt}, 64'd8);
        chk("addi_rs",  {59'd0, id_rs}, 64'd0);

        // ori: zero-extended immediate
        step(0, 0, 0, 1, ORI, 32'h108);
        chk("ori_ext", {63'd0, id_extender_type}, 64'h0);
        chk("ori_op",  {58'd0, id_opcode}, 64'h0D);
        chk("ori_imm", {48'd0, id_imm}, 64'hFFFF);

        // stall for three cycles while IF moves on
        step(0, 0, 0, 1, ADDI, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, ORI, 32'h110);
            chk("stall_hold", {32'd0, id_instr}, {32'd0, ADDI});
        end
        step(0, 0, 0, 1, ORI, 32'h110);
        chk("after_stall", {32'd0, id_instr}, {32'd0, ORI});

        // flush beats stall
        step(0, 1, 1, 1, ADDI, 32'h114);
        chk("flush_instr", {32'd0, id_instr}, 64'h0);
        chk("flush_valid", {63'd0, id_valid}, 64'h0);
        chk("flush_ext",   {63'd0, id_extender_type}, 64'h0);
        chk("flush_pc",    {32'd0, id_pc_plus4}, 64'h114);

        // invalid load becomes canonical bubble
        step(0, 0, 0, 0, ADDI, 32'h118);
        chk("bubble_instr", {32'd0, id_instr}, 64'h0);
        chk("bubble_ext",   {63'd0, id_extender_type}, 64'h0);

        // reset mid-stall
        step(1, 1, 1, 1, ADDI, 32'h11C);
        chk("rst_pc", {32'd0, id_pc_plus4}, 64'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:26] = 6'($urandom_range(10, 17));
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 80,
                 ins, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
